// File: rtl/sram_access_controller.sv
// Purpose: splits 32-bit MEM-stage loads/stores into two 16-bit async SRAM accesses (low half, then high half).
// Latency: 1 + 2*(WAIT_CYCLES+1) + 1 cycles from request to ready=1; read_data is registered.
// Backpressure: ready drops as soon as a request is seen in IDLE and rises for one cycle in DONE; the pipeline freezes on ~ready.
module sram_access_controller #(
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [31:0] ADDR_BASE   = 32'd1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   output logic [17:0] SRAM_ADDR,
   output logic        SRAM_WE_N,
   output logic [15:0] SRAM_DQ_out,
   output logic        SRAM_DQ_oe,
   input  logic [15:0] SRAM_DQ_in
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOW  = 2'd1,
      S_HIGH = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Counter is 3 bits wide, enough for the full 0..7 wait range.
   localparam logic [2:0] LP_WAIT = 3'(WAIT_CYCLES);

   state_t      r_state;
   state_t      w_next_state;
   logic [2:0]  r_counter;
   logic        r_is_write;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_read_data;

   logic        w_req;
   logic        w_phase_done;
   logic [31:0] w_offset;
   logic [16:0] w_hw_idx;

   assign w_req        = rd_en | wr_en;
   assign w_phase_done = (r_counter == LP_WAIT);

   // Offset wraps modulo 2^32; the two low byte-offset bits are dropped
   // and bit 0 of the SRAM address selects the half-word.
   assign w_offset = r_addr - ADDR_BASE;
   assign w_hw_idx = 17'(w_offset >> 2);

   // State register; reset aborts any access in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state: each half-word phase holds for WAIT_CYCLES+1 cycles.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_req)        w_next_state = S_LOW;
         S_LOW:   if (w_phase_done) w_next_state = S_HIGH;
         S_HIGH:  if (w_phase_done) w_next_state = S_DONE;
         S_DONE:                    w_next_state = S_IDLE;
         default:                   w_next_state = S_IDLE;
      endcase
   end

   // Request latch and phase counter; inputs are only sampled in IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_counter  <= 3'd0;
         r_is_write <= 1'b0;
         r_addr     <= 32'd0;
         r_wdata    <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_counter <= 3'd0;
               if (w_req) begin
                  // A simultaneous read and write request is served as a write.
                  r_is_write <= wr_en;
                  r_addr     <= address;
                  r_wdata    <= write_data;
               end
            end
            S_LOW, S_HIGH: begin
               if (w_phase_done) r_counter <= 3'd0;
               else              r_counter <= r_counter + 3'd1;
            end
            default: r_counter <= 3'd0;
         endcase
      end
   end

   // Load capture at the last cycle of each read phase; writes never touch it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_read_data <= 32'd0;
      end else if (!r_is_write && w_phase_done) begin
         if (r_state == S_LOW)  r_read_data[15:0]  <= SRAM_DQ_in;
         if (r_state == S_HIGH) r_read_data[31:16] <= SRAM_DQ_in;
      end
   end

   // SRAM pin drive, decoded from the registered state so reset takes effect at once.
   always_comb begin
      SRAM_ADDR   = 18'd0;
      SRAM_WE_N   = 1'b1;
      SRAM_DQ_oe  = 1'b0;
      SRAM_DQ_out = 16'd0;
      case (r_state)
         S_LOW: begin
            SRAM_ADDR = {w_hw_idx, 1'b0};
            if (r_is_write) begin
               SRAM_WE_N   = 1'b0;
               SRAM_DQ_oe  = 1'b1;
               SRAM_DQ_out = r_wdata[15:0];
            end
         end
         S_HIGH: begin
            SRAM_ADDR = {w_hw_idx, 1'b1};
            if (r_is_write) begin
               SRAM_WE_N   = 1'b0;
               SRAM_DQ_oe  = 1'b1;
               SRAM_DQ_out = r_wdata[31:16];
            end
         end
         default: ;
      endcase
   end

   assign ready     = ((r_state == S_IDLE) && !w_req) || (r_state == S_DONE);
   assign read_data = r_read_data;

endmodule

// File: tb/tb_sram_access_controller.sv
// Directed bench: WAIT_CYCLES=1 instance for the main scenarios, WAIT_CYCLES=0 instance for the short-latency case.
// Each DUT has its own behavioural SRAM that writes on the clock edge while WE_N is low.
// Inputs change #1 after posedge; outputs are checked on negedge.
module tb_sram_access_controller;

   logic        clk;
   logic        rst;

   logic        rd_en1, wr_en1;
   logic [31:0] addr_in1, wdata1, rdata1;
   logic        ready1, we_n1, oe1;
   logic [17:0] sa1;
   logic [15:0] dq_out1, dq_in1;

   logic        rd_en0, wr_en0;
   logic [31:0] addr_in0, wdata0, rdata0;
   logic        ready0, we_n0, oe0;
   logic [17:0] sa0;
   logic [15:0] dq_out0, dq_in0;

   logic [15:0] mem1 [0:262143];
   logic [15:0] mem0 [0:262143];

   int tests_run    = 0;
   int tests_failed = 0;

   sram_access_controller #(.WAIT_CYCLES(1), .ADDR_BASE(32'd1024)) dut1 (
      .clk(clk), .rst(rst), .rd_en(rd_en1), .wr_en(wr_en1),
      .address(addr_in1), .write_data(wdata1), .read_data(rdata1), .ready(ready1),
      .SRAM_ADDR(sa1), .SRAM_WE_N(we_n1), .SRAM_DQ_out(dq_out1), .SRAM_DQ_oe(oe1),
      .SRAM_DQ_in(dq_in1)
   );

   sram_access_controller #(.WAIT_CYCLES(0), .ADDR_BASE(32'd1024)) dut0 (
      .clk(clk), .rst(rst), .rd_en(rd_en0), .wr_en(wr_en0),
      .address(addr_in0), .write_data(wdata0), .read_data(rdata0), .ready(ready0),
      .SRAM_ADDR(sa0), .SRAM_WE_N(we_n0), .SRAM_DQ_out(dq_out0), .SRAM_DQ_oe(oe0),
      .SRAM_DQ_in(dq_in0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural SRAM models.
   always @(posedge clk) if (!we_n1) mem1[sa1] <= dq_out1;
   always @(posedge clk) if (!we_n0) mem0[sa0] <= dq_out0;
   assign dq_in1 = mem1[sa1];
   assign dq_in0 = mem0[sa0];

   task automatic test_reset();
      rst = 1'b1;
      #12;
      tests_run++;
      if (ready1 !== 1'b1 || we_n1 !== 1'b1 || oe1 !== 1'b0 || rdata1 !== 32'd0 || sa1 !== 18'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs: ready=%b we_n=%b oe=%b rdata=%h addr=%h, want 1 1 0 0 0",
                  ready1, we_n1, oe1, rdata1, sa1);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         tests_run++;
         if (ready1 !== 1'b1 || we_n1 !== 1'b1 || oe1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle[%0d]: ready=%b we_n=%b oe=%b, want 1 1 0", i, ready1, we_n1, oe1);
         end
      end
   endtask

   // Write sequence on dut1; 'corrupt' scribbles over address/data in cycle 2 while holding wr_en.
   task automatic test_write(input string nm, input logic [31:0] a, input logic [31:0] d,
                             input logic both, input logic corrupt, input logic [17:0] lo,
                             input logic [31:0] rd_keep);
      logic        exp_ready, exp_we;
      logic [17:0] exp_addr;
      logic [15:0] exp_dq;
      @(posedge clk); #1;
      wr_en1 = 1'b1; rd_en1 = both; addr_in1 = a; wdata1 = d;
      for (int c = 0; c < 6; c++) begin
         exp_ready = (c == 5);
         exp_we    = !(c >= 1 && c <= 4);
         exp_addr  = (c == 1 || c == 2) ? lo : (c == 3 || c == 4) ? lo + 18'd1 : 18'd0;
         exp_dq    = (c == 1 || c == 2) ? d[15:0] : (c == 3 || c == 4) ? d[31:16] : 16'd0;
         @(negedge clk);
         tests_run++;
         if (ready1 !== exp_ready || we_n1 !== exp_we || oe1 !== !exp_we ||
             sa1 !== exp_addr || dq_out1 !== exp_dq || rdata1 !== rd_keep) begin
            tests_failed++;
            $display("FAIL %s cyc%0d: ready=%b we_n=%b oe=%b addr=%h dq=%h rdata=%h, want %b %b %b %h %h %h",
                     nm, c, ready1, we_n1, oe1, sa1, dq_out1, rdata1,
                     exp_ready, exp_we, !exp_we, exp_addr, exp_dq, rd_keep);
         end
         @(posedge clk); #1;
         if (!corrupt && c == 0) begin wr_en1 = 1'b0; rd_en1 = 1'b0; end
         if (corrupt && c == 1) begin addr_in1 = 32'hFFFF_FFFF; wdata1 = 32'hFFFF_FFFF; end
         if (c == 4) begin wr_en1 = 1'b0; rd_en1 = 1'b0; end
      end
      tests_run++;
      if (mem1[lo] !== d[15:0] || mem1[lo + 18'd1] !== d[31:16] || ready1 !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s_mem: lo=%h hi=%h ready=%b, want %h %h 1",
                  nm, mem1[lo], mem1[lo + 18'd1], ready1, d[15:0], d[31:16]);
      end
   endtask

   task automatic test_read();
      logic        exp_ready;
      logic [17:0] exp_addr;
      logic [31:0] exp_rd;
      @(posedge clk); #1;
      rd_en1 = 1'b1; addr_in1 = 32'd1028;
      for (int c = 0; c < 6; c++) begin
         exp_ready = (c == 5);
         exp_addr  = (c == 1 || c == 2) ? 18'd2 : (c == 3 || c == 4) ? 18'd3 : 18'd0;
         exp_rd    = (c < 3) ? 32'd0 : (c < 5) ? 32'h0000_BEEF : 32'hDEAD_BEEF;
         @(negedge clk);
         tests_run++;
         if (ready1 !== exp_ready || we_n1 !== 1'b1 || oe1 !== 1'b0 ||
             sa1 !== exp_addr || rdata1 !== exp_rd) begin
            tests_failed++;
            $display("FAIL read cyc%0d: ready=%b we_n=%b oe=%b addr=%h rdata=%h, want %b 1 0 %h %h",
                     c, ready1, we_n1, oe1, sa1, rdata1, exp_ready, exp_addr, exp_rd);
         end
         @(posedge clk); #1;
         if (c == 0) rd_en1 = 1'b0;
      end
   endtask

   task automatic test_reset_midread();
      @(posedge clk); #1;
      rd_en1 = 1'b1; addr_in1 = 32'd1028;
      @(posedge clk); #1;
      rd_en1 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      tests_run++;
      if (ready1 !== 1'b0 || sa1 !== 18'd3) begin
         tests_failed++;
         $display("FAIL midread_before_rst: ready=%b addr=%h, want 0 3", ready1, sa1);
      end
      rst = 1'b1;
      #1;
      tests_run++;
      if (ready1 !== 1'b1 || we_n1 !== 1'b1 || rdata1 !== 32'd0 || sa1 !== 18'd0) begin
         tests_failed++;
         $display("FAIL midread_rst: ready=%b we_n=%b rdata=%h addr=%h, want 1 1 0 0",
                  ready1, we_n1, rdata1, sa1);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if (ready1 !== 1'b1 || rdata1 !== 32'd0) begin
         tests_failed++;
         $display("FAIL midread_after_rst: ready=%b rdata=%h, want 1 0", ready1, rdata1);
      end
   endtask

   // WAIT_CYCLES=0: IDLE, LOW, HIGH, DONE -> ready on the 4th cycle.
   task automatic test_wait0();
      logic        exp_we;
      logic [17:0] exp_addr;
      @(posedge clk); #1;
      wr_en0 = 1'b1; addr_in0 = 32'd1028; wdata0 = 32'hA5A5_5A5A;
      for (int c = 0; c < 4; c++) begin
         exp_we   = !(c == 1 || c == 2);
         exp_addr = (c == 1) ? 18'd2 : (c == 2) ? 18'd3 : 18'd0;
         @(negedge clk);
         tests_run++;
         if (ready0 !== (c == 3) || we_n0 !== exp_we || sa0 !== exp_addr) begin
            tests_failed++;
            $display("FAIL wait0_write cyc%0d: ready=%b we_n=%b addr=%h, want %b %b %h",
                     c, ready0, we_n0, sa0, (c == 3), exp_we, exp_addr);
         end
         @(posedge clk); #1;
         if (c == 0) wr_en0 = 1'b0;
      end
      rd_en0 = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         tests_run++;
         if (ready0 !== (c == 3) || oe0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL wait0_read cyc%0d: ready=%b oe=%b, want %b 0", c, ready0, oe0, (c == 3));
         end
         @(posedge clk); #1;
         if (c == 0) rd_en0 = 1'b0;
      end
      tests_run++;
      if (rdata0 !== 32'hA5A5_5A5A) begin
         tests_failed++;
         $display("FAIL wait0_rdata: got %h, want a5a55a5a", rdata0);
      end
   endtask

   initial begin
      rd_en1 = 1'b0; wr_en1 = 1'b0; addr_in1 = 32'd0; wdata1 = 32'd0;
      rd_en0 = 1'b0; wr_en0 = 1'b0; addr_in0 = 32'd0; wdata0 = 32'd0;
      test_reset();
      test_write("write", 32'd1028, 32'hDEAD_BEEF, 1'b0, 1'b0, 18'd2, 32'd0);
      test_read();
      test_write("rdwr", 32'd1024, 32'h1234_5678, 1'b1, 1'b0, 18'd0, 32'hDEAD_BEEF);
      test_write("ignore_change", 32'd1028, 32'hDEAD_BEEF, 1'b0, 1'b1, 18'd2, 32'hDEAD_BEEF);
      test_reset_midread();
      test_wait0();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
